// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants for the 1x3 router datapath
// Contents: data byte width, destination address encodings, header field slices.
package router_pkg;

    localparam int DW = 8;

    // Destination address carried in the header byte
    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Header field slices: addr = [1:0], length = [7:2]
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    function automatic logic [1:0] hdr_addr(input logic [DW-1:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

    function automatic logic [5:0] hdr_length(input logic [DW-1:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath register stage (header, FIFO write data, parity check)
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   pkt_valid, data_in       source byte stream (pkt_valid low on the parity byte)
//   fifo_full                selected FIFO full
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                            one-hot state strobes from router_fsm
//   parity_done, low_pkt_valid  status back to router_fsm
//   err                      parity mismatch flag
//   dout                     FIFO write data
module router_reg #(
    parameter int DW = router_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          lfd_state,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic          err,
    output logic [DW-1:0] dout
);
    import router_pkg::*;

    logic [DW-1:0] header_q,     header_d;
    logic [DW-1:0] full_byte_q,  full_byte_d;
    logic [DW-1:0] dout_q,       dout_d;
    logic [DW-1:0] int_parity_q, int_parity_d;
    logic [DW-1:0] pkt_parity_q, pkt_parity_d;
    logic          parity_done_q,   parity_done_d;
    logic          low_pkt_valid_q, low_pkt_valid_d;
    logic          err_q,           err_d;

    // Parity byte accepted either straight off the bus or, if the FIFO was
    // full when it arrived, out of the holding register during LAF.
    logic pkt_par_direct;
    logic pkt_par_laf;

    always_comb begin
        pkt_par_direct = ld_state && !fifo_full && !pkt_valid;
        pkt_par_laf    = laf_state && low_pkt_valid_q && !parity_done_q;
    end

    // Header capture and FIFO write data
    always_comb begin
        header_d    = header_q;
        full_byte_d = full_byte_q;
        dout_d      = dout_q;

        if (detect_add && pkt_valid && (hdr_addr(data_in) != ADDR_INVALID)) begin
            header_d = data_in;
        end

        if (lfd_state) begin
            dout_d = header_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            // FIFO cannot take this byte; park it until LAF replays it
            full_byte_d = data_in;
        end else if (laf_state) begin
            dout_d = full_byte_q;
        end
    end

    // Running parity accumulator. The byte parked in full_byte is folded in
    // on arrival, so LAF does not fold it again.
    always_comb begin
        int_parity_d = int_parity_q;
        if (detect_add) begin
            int_parity_d = '0;
        end else if (lfd_state) begin
            int_parity_d = int_parity_q ^ header_q;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity_d = int_parity_q ^ data_in;
        end
    end

    // Packet parity capture and status flags
    always_comb begin
        pkt_parity_d    = pkt_parity_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        err_d           = err_q;

        if (pkt_par_direct) begin
            pkt_parity_d  = data_in;
            parity_done_d = 1'b1;
        end else if (pkt_par_laf) begin
            pkt_parity_d  = full_byte_q;
            parity_done_d = 1'b1;
        end else if (detect_add) begin
            parity_done_d = 1'b0;
        end

        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end

        // detect_add wins so a stale parity_done from the previous packet
        // cannot re-raise err on the new packet's first cycle.
        if (detect_add) begin
            err_d = 1'b0;
        end else if (parity_done_q) begin
            err_d = (int_parity_q != pkt_parity_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            header_q        <= '0;
            full_byte_q     <= '0;
            dout_q          <= '0;
            int_parity_q    <= '0;
            pkt_parity_q    <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            header_q        <= header_d;
            full_byte_q     <= full_byte_d;
            dout_q          <= dout_d;
            int_parity_q    <= int_parity_d;
            pkt_parity_q    <= pkt_parity_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - directed-vector bench for router_reg
module tb_router_reg;

    localparam int DW = 8;

    // Strobe selector bits: {rst_int_reg, full_state, laf_state, ld_state, lfd_state, detect_add}
    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_DET  = 6'b000001;
    localparam logic [5:0] S_LFD  = 6'b000010;
    localparam logic [5:0] S_LD   = 6'b000100;
    localparam logic [5:0] S_LAF  = 6'b001000;
    localparam logic [5:0] S_FULL = 6'b010000;
    localparam logic [5:0] S_CPE  = 6'b100000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          fifo_full = 1'b0;
    logic          detect_add = 1'b0;
    logic          lfd_state = 1'b0;
    logic          ld_state = 1'b0;
    logic          laf_state = 1'b0;
    logic          full_state = 1'b0;
    logic          rst_int_reg = 1'b0;
    logic          parity_done;
    logic          low_pkt_valid;
    logic          err;
    logic [DW-1:0] dout;

    int n_vec = 0;
    int n_miss = 0;

    router_reg #(.DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
        .dout          (dout)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
        detect_add  = st[0];
        lfd_state   = st[1];
        ld_state    = st[2];
        laf_state   = st[3];
        full_state  = st[4];
        rst_int_reg = st[5];
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    endtask

    // Header 0x0D (addr 01, length 3), payload 11/22/33: parity = 0x0D.
    task automatic send_packet(input logic [7:0] par, input logic exp_err);
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        check_vec("det_pdone_clr", {7'b0, parity_done}, 8'h00);
        check_vec("det_err_clr",   {7'b0, err},         8'h00);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        check_vec("lfd_dout", dout, 8'h0D);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        check_vec("ld0_dout", dout, 8'h11);
        cyc(S_LD, 1'b1, 8'h22, 1'b0);
        check_vec("ld1_dout", dout, 8'h22);
        cyc(S_LD, 1'b1, 8'h33, 1'b0);
        check_vec("ld2_dout", dout, 8'h33);
        check_vec("ld2_pdone", {7'b0, parity_done}, 8'h00);
        cyc(S_LD, 1'b0, par, 1'b0);
        check_vec("par_dout",  dout, par);
        check_vec("par_pdone", {7'b0, parity_done},   8'h01);
        check_vec("par_lpv",   {7'b0, low_pkt_valid}, 8'h01);
        check_vec("par_err_pending", {7'b0, err},     8'h00);
        cyc(S_CPE, 1'b0, 8'h00, 1'b0);
        check_vec("cpe_err", {7'b0, err},           {7'b0, exp_err});
        check_vec("cpe_lpv", {7'b0, low_pkt_valid}, 8'h00);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        #2;
        check_vec("rst_dout",  dout, 8'h00);
        check_vec("rst_pdone", {7'b0, parity_done},   8'h00);
        check_vec("rst_lpv",   {7'b0, low_pkt_valid}, 8'h00);
        check_vec("rst_err",   {7'b0, err},           8'h00);
        do_reset();

        // Invalid address from reset: header stays 0x00
        cyc(S_DET, 1'b1, 8'h0F, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        check_vec("inv_rst_hdr", dout, 8'h00);

        // Good packet
        send_packet(8'h0D, 1'b0);

        // Invalid address after a good header: header keeps 0x0D
        cyc(S_DET, 1'b1, 8'h0F, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        check_vec("inv_keep_hdr", dout, 8'h0D);

        // Bad parity: err raised and held until next detect_add
        send_packet(8'h0E, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(S_IDLE, 1'b0, 8'h55, 1'b0);
            check_vec("bad_err_hold", {7'b0, err}, 8'h01);
        end
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        check_vec("bad_err_clr",   {7'b0, err},         8'h00);
        check_vec("bad_pdone_clr", {7'b0, parity_done}, 8'h00);

        // FIFO full mid-payload (already in DECODE_ADDRESS with header 0x0D)
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        check_vec("mf_ld0", dout, 8'h11);
        cyc(S_LD, 1'b1, 8'h22, 1'b1);
        check_vec("mf_hold", dout, 8'h11);
        cyc(S_FULL, 1'b1, 8'h99, 1'b1);
        check_vec("mf_full_hold", dout, 8'h11);
        cyc(S_LAF, 1'b1, 8'h99, 1'b0);
        check_vec("mf_laf", dout, 8'h22);
        check_vec("mf_laf_pdone", {7'b0, parity_done}, 8'h00);
        cyc(S_LD, 1'b1, 8'h33, 1'b0);
        check_vec("mf_ld2", dout, 8'h33);
        cyc(S_LD, 1'b0, 8'h0D, 1'b0);
        check_vec("mf_par_pdone", {7'b0, parity_done}, 8'h01);
        cyc(S_CPE, 1'b0, 8'h00, 1'b0);
        check_vec("mf_err", {7'b0, err}, 8'h00);

        // FIFO full exactly on the parity byte; parity completes in LAF
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD, 1'b1, 8'h22, 1'b0);
        cyc(S_LD, 1'b1, 8'h33, 1'b0);
        cyc(S_LD, 1'b0, 8'h0D, 1'b1);
        check_vec("fp_hold",  dout, 8'h33);
        check_vec("fp_pdone", {7'b0, parity_done},   8'h00);
        check_vec("fp_lpv",   {7'b0, low_pkt_valid}, 8'h01);
        cyc(S_FULL, 1'b0, 8'hAA, 1'b1);
        check_vec("fp_full_pdone", {7'b0, parity_done}, 8'h00);
        cyc(S_LAF, 1'b0, 8'hAA, 1'b0);
        check_vec("fp_laf_dout",  dout, 8'h0D);
        check_vec("fp_laf_pdone", {7'b0, parity_done}, 8'h01);
        cyc(S_CPE, 1'b0, 8'h00, 1'b0);
        check_vec("fp_err", {7'b0, err}, 8'h00);

        // Same boundary with a wrong parity byte parked in full_byte
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD, 1'b1, 8'h22, 1'b0);
        cyc(S_LD, 1'b1, 8'h33, 1'b0);
        cyc(S_LD, 1'b0, 8'h4C, 1'b1);
        cyc(S_FULL, 1'b0, 8'h0D, 1'b1);
        cyc(S_LAF, 1'b0, 8'h0D, 1'b0);
        check_vec("fpb_laf_dout", dout, 8'h4C);
        cyc(S_CPE, 1'b0, 8'h00, 1'b0);
        check_vec("fpb_err", {7'b0, err}, 8'h01);

        // Asynchronous reset mid-packet, asserted between clock edges
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD, 1'b0, 8'h0D, 1'b0);
        check_vec("ar_pre_dout",  dout, 8'h0D);
        check_vec("ar_pre_pdone", {7'b0, parity_done}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        check_vec("ar_dout",  dout, 8'h00);
        check_vec("ar_pdone", {7'b0, parity_done},   8'h00);
        check_vec("ar_lpv",   {7'b0, low_pkt_valid}, 8'h00);
        check_vec("ar_err",   {7'b0, err},           8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Header must have been cleared too
        cyc(S_DET, 1'b1, 8'h0F, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        check_vec("ar_hdr", dout, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
Datapath register stage of the 1x3 router, directly downstream of router_fsm. It consumes the FSM state strobes and:
- captures the header byte;
- forwards header and payload bytes to the FIFO write bus;
- holds the byte that arrived while the FIFO was full;
- computes running parity and compares it against the packet's parity byte.
It produces parity_done and low_pkt_valid back to router_fsm and err to the top level.

Parameters:
DW, 8, data byte width (header, payload, parity, dout)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
pkt_valid  input  1  source asserts while header/payload bytes are on data_in; low on the parity byte
data_in  input  DW  incoming byte from source
fifo_full  input  1  selected FIFO full (from router_sync)
detect_add  input  1  FSM in DECODE_ADDRESS
lfd_state  input  1  FSM in LOAD_FIRST_DATA
ld_state  input  1  FSM in LOAD_DATA
laf_state  input  1  FSM in LOAD_AFTER_FULL
full_state  input  1  FSM in FIFO_FULL_STATE
rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid
parity_done  output  1  parity byte captured; tells FSM to leave LOAD_PARITY/LAF
low_pkt_valid  output  1  pkt_valid dropped while in LOAD_DATA
err  output  1  computed parity != received parity
dout  output  DW  byte to FIFO write data bus

Behaviour:
- Reset (rst=0, asynchronous): dout, header, full_byte, int_parity, pkt_parity = 0; parity_done, low_pkt_valid, err = 0.
- All registers below update on the rising clk edge when rst=1.
- Header capture:
  - Condition: detect_add && pkt_valid && data_in[1:0]!=2'b11.
  - Action: header <= data_in.
  - Otherwise header holds.
- dout, evaluated in strict priority order:
  - lfd_state: dout <= header.
  - ld_state && !fifo_full: dout <= data_in.
  - ld_state && fifo_full: full_byte <= data_in; dout holds.
  - laf_state: dout <= full_byte.
  - otherwise: dout holds.
  - Latency: one cycle from state strobe to dout.
- int_parity:
  - detect_add: cleared to 0.
  - lfd_state: ^= header.
  - ld_state && pkt_valid && !full_state: ^= data_in.
  - otherwise: holds.
  - The parity byte itself is never folded in, because pkt_valid=0 on that byte.
- pkt_parity:
  - Condition: (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done). In the laf_state case the byte is full_byte.
  - Action: pkt_parity <= data_in, or full_byte in the laf_state case.
- parity_done:
  - Set on the same pkt_parity conditions above.
  - Cleared by detect_add.
  - Set has priority over clear; both asserted in the same cycle cannot occur in a legal FSM sequence.
- low_pkt_valid:
  - Set when ld_state && !pkt_valid.
  - Cleared when rst_int_reg.
  - Clear has priority over set.
- err:
  - While parity_done=1: err <= (int_parity != pkt_parity). err therefore settles one cycle after parity_done rises.
  - Cleared by detect_add.
  - Held otherwise, so err stays visible until the next packet's DECODE_ADDRESS.
- Boundary cases:
  - fifo_full exactly on the parity byte: the byte goes to full_byte, and parity completes in LAF via the laf_state path.
  - Address 2'b11 in DECODE_ADDRESS: header is not updated.
  - Reset mid-packet clears everything immediately, with no partial-packet state retained.
  - Multiple simultaneous state strobes are illegal (the FSM is one-hot); dout priority is as listed above.

Decomposition:
- Package router_pkg:
  - DW;
  - address encoding constants ADDR_0=2'b00, ADDR_1=2'b01, ADDR_2=2'b10, ADDR_INVALID=2'b11;
  - header field slices: addr=[1:0], length=[7:2].
- No sub-module. The parity accumulator is a single always block inside router_reg.

Test Plan:
- Good packet:
  - Stimulus: reset; detect_add with data_in=0x0D, pkt_valid=1; lfd; ld with 0x11, 0x22, 0x33; pkt_valid=0 with parity byte 0x0D.
  - Response: dout sequence 0x0D, 0x11, 0x22, 0x33, 0x0D; parity_done=1 one cycle after the parity byte; err=0 the following cycle; low_pkt_valid=1.
- Bad parity:
  - Stimulus: same packet, parity byte 0x0E.
  - Response: err=1 one cycle after parity_done, held until the next detect_add, then err=0 and parity_done=0.
- FIFO full mid-payload:
  - Stimulus: fifo_full=1 while data_in=0x22 in ld_state.
  - Response: dout holds 0x11; after full_state then laf_state, dout=0x22; final err=0 with correct parity 0x0D.
- Full on parity byte:
  - Stimulus: fifo_full=1 when the parity byte 0x0D arrives, then laf_state with low_pkt_valid=1.
  - Response: pkt_parity=0x0D captured in LAF; parity_done=1; err=0.
- Invalid address:
  - Stimulus: detect_add with data_in=0x0F.
  - Response: header unchanged from previous value (reset value 0x00).
- Async reset mid-packet:
  - Stimulus: rst=0 during ld_state, asserted between clock edges.
  - Response: dout=0, parity_done=0, low_pkt_valid=0, err=0 without waiting for a clock edge.
